usb_rx_phy: RTL and testbench

Full-speed USB receive front end. Consumes the synchronised-to-pad `usb_p_rx`/`usb_n_rx` pair produced by the pin/pad wrapper and delivers decoded packet bytes to the DFU protocol core. It recovers the 12 Mb/s bit clock from the 48 MHz system clock (4× oversampling), NRZI-decodes, removes stuffed bits, detects SYNC and EOP, and assembles bytes.

---
 rtl/usb_rx_phy.sv | 264 ++++++++++++++++++++++++++
 tb/tb_usb_rx_phy.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_phy.sv
// Full-speed USB receive front end: pad synchroniser, 4x DPLL, NRZI decode, bit destuffing,
// SYNC/EOP detection and byte assembly. Define USB_RX_BUS_RESET_EN to enable long-SE0 bus_reset.
module usb_rx_phy #(
    parameter int BUS_RESET_CYCLES = 120
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic       rx_pkt_start,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_pkt_end,
    output logic       rx_err,
    output logic       bus_reset
);
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_DATA     = 3'd2,
        ST_EOP_WAIT = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    logic [1:0] meta_r;
    logic [1:0] ls_r;
    logic [1:0] ls_prev_r;
    logic [1:0] phase_r;
    logic [1:0] phase_s;

    state_t     state_r,    state_s;
    logic       prev_dp_r,  prev_dp_s;
    logic [2:0] zero_cnt_r, zero_cnt_s;
    logic [2:0] ones_cnt_r, ones_cnt_s;
    logic [2:0] bit_cnt_r,  bit_cnt_s;
    logic [2:0] j_cnt_r,    j_cnt_s;
    logic [6:0] shift_r,    shift_s;
    logic [7:0] data_r,     data_s;
    logic       active_r,   active_s;
    logic       start_r,    start_s;
    logic       valid_r,    valid_s;
    logic       end_r,      end_s;
    logic       err_r,      err_s;

    logic       sample_s;
    logic       bit_s;
    logic       se0_s;

    // Two-flop synchroniser, one cycle of line-state history and the DPLL phase counter
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            meta_r    <= LS_J;
            ls_r      <= LS_J;
            ls_prev_r <= LS_J;
            phase_r   <= 2'd0;
        end else begin
            meta_r    <= {usb_p_rx, usb_n_rx};
            ls_r      <= meta_r;
            ls_prev_r <= ls_r;
            phase_r   <= phase_s;
        end
    end

    // A dp edge seen one stage early realigns the phase so sampling lands mid-cell
    always_comb begin
        if ((meta_r[1] != ls_r[1]) && (meta_r != LS_SE0)) begin
            phase_s = 2'd0;
        end else begin
            phase_s = phase_r + 2'd1;
        end
    end

    assign sample_s = (phase_r == 2'd2);
    assign se0_s    = (ls_r == LS_SE0);
    assign bit_s    = (ls_r[1] == prev_dp_r);

    // Packet FSM state and registered outputs
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            prev_dp_r  <= 1'b1;
            zero_cnt_r <= 3'd0;
            ones_cnt_r <= 3'd0;
            bit_cnt_r  <= 3'd0;
            j_cnt_r    <= 3'd0;
            shift_r    <= 7'd0;
            data_r     <= 8'd0;
            active_r   <= 1'b0;
            start_r    <= 1'b0;
            valid_r    <= 1'b0;
            end_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            prev_dp_r  <= prev_dp_s;
            zero_cnt_r <= zero_cnt_s;
            ones_cnt_r <= ones_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            j_cnt_r    <= j_cnt_s;
            shift_r    <= shift_s;
            data_r     <= data_s;
            active_r   <= active_s;
            start_r    <= start_s;
            valid_r    <= valid_s;
            end_r      <= end_s;
            err_r      <= err_s;
        end
    end

    // Next-state, decode, destuff and byte assembly
    always_comb begin
        state_s    = state_r;
        zero_cnt_s = zero_cnt_r;
        ones_cnt_s = ones_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        j_cnt_s    = j_cnt_r;
        shift_s    = shift_r;
        data_s     = data_r;
        active_s   = active_r;
        start_s    = 1'b0;
        valid_s    = 1'b0;
        end_s      = 1'b0;
        err_s      = 1'b0;

        // Idle holds the NRZI reference at J so the first SYNC K decodes as a zero
        if (sample_s) begin
            prev_dp_s = ls_r[1];
        end else if (state_r == ST_IDLE) begin
            prev_dp_s = 1'b1;
        end else begin
            prev_dp_s = prev_dp_r;
        end

        case (state_r)
            ST_IDLE: begin
                zero_cnt_s = 3'd0;
                active_s   = 1'b0;
                if (sample_s && (ls_r == LS_K)) begin
                    state_s = ST_SYNC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (!sample_s) begin
                    state_s = ST_SYNC;
                end else if (se0_s) begin
                    state_s = ST_IDLE;
                end else if (!bit_s) begin
                    zero_cnt_s = (zero_cnt_r == 3'd7) ? 3'd7 : zero_cnt_r + 3'd1;
                end else if (zero_cnt_r >= 3'd5) begin
                    state_s    = ST_DATA;
                    start_s    = 1'b1;
                    active_s   = 1'b1;
                    ones_cnt_s = 3'd0;
                    bit_cnt_s  = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!sample_s) begin
                    state_s = ST_DATA;
                end else if (se0_s) begin
                    end_s    = 1'b1;
                    err_s    = (bit_cnt_r != 3'd0);
                    active_s = 1'b0;
                    state_s  = ST_EOP_WAIT;
                end else if (ones_cnt_r == 3'd6) begin
                    if (bit_s) begin
                        err_s    = 1'b1;
                        active_s = 1'b0;
                        j_cnt_s  = 3'd0;
                        state_s  = ST_ERROR;
                    end else begin
                        ones_cnt_s = 3'd0;
                    end
                end else begin
                    shift_s    = {bit_s, shift_r[6:1]};
                    ones_cnt_s = bit_s ? ones_cnt_r + 3'd1 : 3'd0;
                    if (bit_cnt_r == 3'd7) begin
                        data_s    = {bit_s, shift_r};
                        valid_s   = 1'b1;
                        bit_cnt_s = 3'd0;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end
            end
            ST_EOP_WAIT: begin
                if (ls_r == LS_J) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_EOP_WAIT;
                end
            end
            ST_ERROR: begin
                if ((ls_prev_r == LS_SE0) && (ls_r == LS_J)) begin
                    state_s = ST_IDLE;
                end else if (!sample_s) begin
                    state_s = ST_ERROR;
                end else if (ls_r == LS_J) begin
                    if (j_cnt_r == 3'd7) begin
                        state_s = ST_IDLE;
                    end else begin
                        j_cnt_s = j_cnt_r + 3'd1;
                    end
                end else begin
                    j_cnt_s = 3'd0;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                active_s = 1'b0;
            end
        endcase
    end

    assign line_state   = ls_r;
    assign rx_active    = active_r;
    assign rx_pkt_start = start_r;
    assign rx_data      = data_r;
    assign rx_valid     = valid_r;
    assign rx_pkt_end   = end_r;
    assign rx_err       = err_r;

`ifdef USB_RX_BUS_RESET_EN
    localparam int SE0_W = $clog2(BUS_RESET_CYCLES + 1);
    localparam logic [SE0_W-1:0] SE0_MAX = SE0_W'(BUS_RESET_CYCLES);
    localparam logic [SE0_W-1:0] SE0_ONE = SE0_W'(1);

    logic [SE0_W-1:0] se0_cnt_r;
    logic             bus_reset_r;

    // Saturating SE0 run counter; flag rises when the run reaches the threshold
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            se0_cnt_r   <= '0;
            bus_reset_r <= 1'b0;
        end else if (ls_r == LS_SE0) begin
            if (se0_cnt_r != SE0_MAX) begin
                se0_cnt_r <= se0_cnt_r + SE0_ONE;
            end else begin
                se0_cnt_r <= se0_cnt_r;
            end
            bus_reset_r <= bus_reset_r || (se0_cnt_r == (SE0_MAX - SE0_ONE));
        end else begin
            se0_cnt_r   <= '0;
            bus_reset_r <= 1'b0;
        end
    end

    assign bus_reset = bus_reset_r;
`else
    assign bus_reset = 1'b0 & (BUS_RESET_CYCLES < 0);
`endif

endmodule

// File: tb/tb_usb_rx_phy.sv
// Directed self-checking bench for usb_rx_phy: NRZI/stuffing encoder drives the pads,
// a negedge monitor collects strobes and bytes.
module tb_usb_rx_phy;
    localparam int BRC = 120;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic       clk_48mhz = 1'b0;
    logic       reset_n   = 1'b0;
    logic       usb_p_rx  = 1'b1;
    logic       usb_n_rx  = 1'b0;
    logic [1:0] line_state;
    logic       rx_active, rx_pkt_start, rx_valid, rx_pkt_end, rx_err, bus_reset;
    logic [7:0] rx_data;

    usb_rx_phy #(.BUS_RESET_CYCLES(BRC)) dut (
        .clk_48mhz   (clk_48mhz),
        .reset_n     (reset_n),
        .usb_p_rx    (usb_p_rx),
        .usb_n_rx    (usb_n_rx),
        .line_state  (line_state),
        .rx_active   (rx_active),
        .rx_pkt_start(rx_pkt_start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_pkt_end  (rx_pkt_end),
        .rx_err      (rx_err),
        .bus_reset   (bus_reset)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    int tests_run    = 0;
    int tests_failed = 0;

    int n_start = 0, n_valid = 0, n_end = 0, n_err = 0, n_end_err = 0, n_clash = 0;
    int b_start, b_valid, b_end, b_err, b_end_err, b_clash;
    logic [7:0] got_bytes [0:63];

    bit bitq[$];
    int ones_run;

    always @(negedge clk_48mhz) begin
        if (rx_valid) begin
            if (n_valid < 64) got_bytes[n_valid] = rx_data;
            n_valid++;
        end
        if (rx_pkt_start) n_start++;
        if (rx_pkt_end) n_end++;
        if (rx_err) n_err++;
        if (rx_pkt_end && rx_err) n_end_err++;
        if (rx_valid && (rx_pkt_start || rx_pkt_end)) n_clash++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        b_start = n_start; b_valid = n_valid; b_end = n_end;
        b_err = n_err; b_end_err = n_end_err; b_clash = n_clash;
    endtask

    function automatic logic [7:0] byte_at(input int i);
        int idx;
        idx = b_valid + i;
        if (idx < 64) return got_bytes[idx];
        return 8'hxx;
    endfunction

    task automatic drive(input logic [1:0] ls, input int n);
        {usb_p_rx, usb_n_rx} = ls;
        repeat (n) @(negedge clk_48mhz);
    endtask

    task automatic q_sync();
        for (int i = 0; i < 7; i++) bitq.push_back(1'b0);
        bitq.push_back(1'b1);
        ones_run = 0;
    endtask

    task automatic q_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            bitq.push_back(b[i]);
            if (b[i]) ones_run++;
            else ones_run = 0;
            if (ones_run == 6) begin
                bitq.push_back(1'b0);
                ones_run = 0;
            end
        end
    endtask

    task automatic q_raw(input bit v, input int n);
        for (int i = 0; i < n; i++) bitq.push_back(v);
    endtask

    // NRZI-encode the queue from J; jitter alternates 3- and 5-clock cells
    task automatic tx(input bit jitter, input bit eop);
        logic lvl;
        int   len;
        lvl = 1'b1;
        for (int i = 0; i < bitq.size(); i++) begin
            if (!bitq[i]) lvl = ~lvl;
            len = jitter ? (((i % 2) == 0) ? 3 : 5) : 4;
            drive(lvl ? J : K, len);
        end
        bitq.delete();
        if (eop) begin
            drive(SE0, 8);
            drive(J, 4);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int hi;

        repeat (3) @(negedge clk_48mhz);
        check("rst_line_state", {30'd0, line_state}, 32'h2);
        check("rst_active", {31'd0, rx_active}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_strobes", {28'd0, rx_pkt_start, rx_valid, rx_pkt_end, rx_err}, 32'd0);
        check("rst_bus_reset", {31'd0, bus_reset}, 32'd0);
        reset_n = 1'b1;
        drive(J, 8);

        // PID 0x69 at nominal bit rate
        mark(); q_sync(); q_byte(8'h69); tx(1'b0, 1'b1); drive(J, 8);
        check("t1_start", n_start - b_start, 1);
        check("t1_nvalid", n_valid - b_valid, 1);
        check("t1_byte", {24'd0, byte_at(0)}, 32'h69);
        check("t1_end", n_end - b_end, 1);
        check("t1_err", n_err - b_err, 0);
        check("t1_active", {31'd0, rx_active}, 32'd0);
        check("t1_data_held", {24'd0, rx_data}, 32'h69);

        // 0xFF 0xFF with stuffed zeros
        mark(); q_sync(); q_byte(8'hFF); q_byte(8'hFF); tx(1'b0, 1'b1); drive(J, 8);
        check("t2_nvalid", n_valid - b_valid, 2);
        check("t2_byte0", {24'd0, byte_at(0)}, 32'hFF);
        check("t2_byte1", {24'd0, byte_at(1)}, 32'hFF);
        check("t2_err", n_err - b_err, 0);
        check("t2_end", n_end - b_end, 1);

        // Seven decoded ones: stuff violation, then recovery via SE0->J
        mark(); q_sync(); q_raw(1'b1, 7); tx(1'b0, 1'b0); drive(K, 16);
        check("t3_err", n_err - b_err, 1);
        check("t3_active", {31'd0, rx_active}, 32'd0);
        check("t3_end", n_end - b_end, 0);
        drive(SE0, 8); drive(J, 8);
        check("t3_quiet_valid", n_valid - b_valid, 0);
        check("t3_quiet_end", n_end - b_end, 0);
        mark(); q_sync(); q_byte(8'hC3); tx(1'b0, 1'b1); drive(J, 8);
        check("t3_next_nvalid", n_valid - b_valid, 1);
        check("t3_next_byte", {24'd0, byte_at(0)}, 32'hC3);
        check("t3_next_err", n_err - b_err, 0);

        // Partial byte at EOP
        mark(); q_sync(); q_raw(1'b1, 1); q_raw(1'b0, 1); q_raw(1'b1, 1); q_raw(1'b0, 1);
        tx(1'b0, 1'b1); drive(J, 8);
        check("t4_end", n_end - b_end, 1);
        check("t4_end_with_err", n_end_err - b_end_err, 1);
        check("t4_err", n_err - b_err, 1);
        check("t4_nvalid", n_valid - b_valid, 0);

        // Jittered 3/5-clock bit cells
        mark(); q_sync(); q_byte(8'hA5); q_byte(8'h3C); tx(1'b1, 1'b1); drive(J, 8);
        check("t5_nvalid", n_valid - b_valid, 2);
        check("t5_byte0", {24'd0, byte_at(0)}, 32'hA5);
        check("t5_byte1", {24'd0, byte_at(1)}, 32'h3C);
        check("t5_err", n_err - b_err, 0);

        // Reset asserted mid-packet
        mark(); q_sync(); q_raw(1'b1, 1); q_raw(1'b0, 1); q_raw(1'b1, 1); tx(1'b0, 1'b0);
        check("t6_active_mid", {31'd0, rx_active}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_active", {31'd0, rx_active}, 32'd0);
        check("t6_rst_data", {24'd0, rx_data}, 32'd0);
        check("t6_rst_line", {30'd0, line_state}, 32'h2);
        {usb_p_rx, usb_n_rx} = J;
        repeat (4) @(negedge clk_48mhz);
        reset_n = 1'b1;
        drive(J, 8);
        check("t6_no_end", n_end - b_end, 0);
        check("t6_no_err", n_err - b_err, 0);
        check("never_coincide", n_clash, 0);

        // Long SE0
        {usb_p_rx, usb_n_rx} = SE0;
        cnt = 0;
        while (line_state != SE0 && cnt < 10) begin
            @(negedge clk_48mhz);
            cnt++;
        end
        check("t7_se0_seen", {30'd0, line_state}, 32'd0);
`ifdef USB_RX_BUS_RESET_EN
        cnt = 0;
        while (!bus_reset && cnt < 300) begin
            @(negedge clk_48mhz);
            cnt++;
        end
        check("t7_rise_cycles", cnt, BRC);
        repeat (200 - BRC) @(negedge clk_48mhz);
        check("t7_held", {31'd0, bus_reset}, 32'd1);
        {usb_p_rx, usb_n_rx} = J;
        cnt = 0;
        while (line_state != J && cnt < 10) begin
            @(negedge clk_48mhz);
            cnt++;
        end
        check("t7_at_j", {31'd0, bus_reset}, 32'd1);
        @(negedge clk_48mhz);
        check("t7_fall", {31'd0, bus_reset}, 32'd0);
`else
        hi = 0;
        repeat (200) begin
            @(negedge clk_48mhz);
            if (bus_reset) hi++;
        end
        check("t7_no_bus_reset", hi, 0);
        drive(J, 8);
        check("t7_low_after", {31'd0, bus_reset}, 32'd0);
`endif
        drive(J, 8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
